// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: three-stage signed pre-add / multiply / post-add slice with
// accumulate feedback, optional saturation, sticky overflow and B/P cascade.
module dsp_mac_pipe #(
    parameter int    AW      = 18,
    parameter int    BW      = 18,
    parameter int    PW      = 48,
    parameter string B_INPUT = "DIRECT",
    parameter bit    SAT_EN  = 1'b1
) (
    input  logic                  clk,
    input  logic                  RST_N,
    input  logic                  CE,
    input  logic                  CLR,
    input  logic                  in_valid,
    input  logic signed [AW-1:0]  A,
    input  logic signed [BW-1:0]  B,
    input  logic signed [BW-1:0]  BCIN,
    input  logic signed [BW-1:0]  D,
    input  logic signed [PW-1:0]  C,
    input  logic signed [PW-1:0]  PCIN,
    input  logic [5:0]            OPMODE,
    output logic signed [BW-1:0]  BCOUT,
    output logic signed [AW+BW:0] M,
    output logic signed [PW-1:0]  P,
    output logic signed [PW-1:0]  PCOUT,
    output logic                  out_valid,
    output logic                  OVF,
    output logic                  OVF_STICKY
);

    localparam bit CASCADE = (B_INPUT == "CASCADE");
    localparam int MW      = AW + BW + 1;

    logic signed [AW-1:0] r_a_p1;
    logic signed [BW-1:0] r_b_p1;
    logic signed [BW-1:0] r_d_p1;
    logic signed [PW-1:0] r_c_p1;
    logic signed [PW-1:0] r_pcin_p1;
    logic [5:0]           r_op_p1;
    logic                 r_vld_p1;

    logic signed [MW-1:0] r_m_p2;
    logic signed [PW-1:0] r_c_p2;
    logic signed [PW-1:0] r_pcin_p2;
    logic [1:0]           r_zsel_p2;
    logic                 r_psub_p2;
    logic                 r_cin_p2;
    logic                 r_vld_p2;

    logic signed [PW-1:0] r_p_p3;
    logic                 r_ovf_p3;
    logic                 r_sticky_p3;
    logic                 r_vld_p3;

    logic signed [BW-1:0] w_b_in;
    logic signed [BW:0]   w_pre_p1;
    logic signed [MW-1:0] w_prod_p1;
    logic signed [PW-1:0] w_z_p2;
    logic signed [PW:0]   w_m_x;
    logic signed [PW:0]   w_z_x;
    logic signed [PW:0]   w_cin_x;
    logic signed [PW:0]   w_sum_p2;
    logic                 w_ovf_p2;

    function automatic logic signed [BW:0] pre_add(input logic signed [BW-1:0] b,
                                                   input logic signed [BW-1:0] d,
                                                   input logic use_pre,
                                                   input logic sub);
        logic signed [BW:0] b_x;
        logic signed [BW:0] d_x;
        b_x = (BW+1)'(b);
        d_x = (BW+1)'(d);
        if (!use_pre) return b_x;
        return sub ? (d_x - b_x) : (d_x + b_x);
    endfunction

    function automatic logic signed [PW-1:0] sat_clamp(input logic signed [PW:0] sum,
                                                       input logic ovf);
        if (SAT_EN && ovf)
            return sum[PW] ? {1'b1, {(PW-1){1'b0}}} : {1'b0, {(PW-1){1'b1}}};
        return sum[PW-1:0];
    endfunction

    assign w_b_in = CASCADE ? BCIN : B;

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_a_p1    <= '0;
            r_b_p1    <= '0;
            r_d_p1    <= '0;
            r_c_p1    <= '0;
            r_pcin_p1 <= '0;
            r_op_p1   <= '0;
            r_vld_p1  <= 1'b0;
        end else if (CLR) begin
            r_b_p1    <= '0;
            r_vld_p1  <= 1'b0;
        end else if (CE) begin
            r_a_p1    <= A;
            r_b_p1    <= w_b_in;
            r_d_p1    <= D;
            r_c_p1    <= C;
            r_pcin_p1 <= PCIN;
            r_op_p1   <= OPMODE;
            r_vld_p1  <= in_valid;
        end
    end

    // Pre-adder keeps BW+1 bits so the product is exact in MW bits.
    assign w_pre_p1  = pre_add(r_b_p1, r_d_p1, r_op_p1[0], r_op_p1[1]);
    assign w_prod_p1 = MW'(r_a_p1) * MW'(w_pre_p1);

    // Stage 2: product register, post-add controls carried with the operation
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_m_p2    <= '0;
            r_c_p2    <= '0;
            r_pcin_p2 <= '0;
            r_zsel_p2 <= '0;
            r_psub_p2 <= 1'b0;
            r_cin_p2  <= 1'b0;
            r_vld_p2  <= 1'b0;
        end else if (CLR) begin
            r_m_p2    <= '0;
            r_vld_p2  <= 1'b0;
        end else if (CE) begin
            r_m_p2    <= w_prod_p1;
            r_c_p2    <= r_c_p1;
            r_pcin_p2 <= r_pcin_p1;
            r_zsel_p2 <= r_op_p1[3:2];
            r_psub_p2 <= r_op_p1[4];
            r_cin_p2  <= r_op_p1[5];
            r_vld_p2  <= r_vld_p1;
        end
    end

    always_comb begin
        w_z_p2 = '0;
        case (r_zsel_p2)
            2'b01:   w_z_p2 = r_p_p3;
            2'b10:   w_z_p2 = r_c_p2;
            2'b11:   w_z_p2 = r_pcin_p2;
            default: w_z_p2 = '0;
        endcase
    end

    assign w_m_x    = (PW+1)'(r_m_p2);
    assign w_z_x    = (PW+1)'(w_z_p2);
    assign w_cin_x  = {{PW{1'b0}}, r_cin_p2};
    assign w_sum_p2 = r_psub_p2 ? (w_z_x - (w_m_x + w_cin_x)) : (w_z_x + w_m_x + w_cin_x);
    assign w_ovf_p2 = w_sum_p2[PW] ^ w_sum_p2[PW-1];

    // Stage 3: post-add result; only a valid operation may disturb P and the flags
    always_ff @(posedge clk or negedge RST_N) begin
        if (!RST_N) begin
            r_p_p3      <= '0;
            r_ovf_p3    <= 1'b0;
            r_sticky_p3 <= 1'b0;
            r_vld_p3    <= 1'b0;
        end else if (CLR) begin
            r_p_p3      <= '0;
            r_ovf_p3    <= 1'b0;
            r_sticky_p3 <= 1'b0;
            r_vld_p3    <= 1'b0;
        end else begin
            r_vld_p3 <= CE & r_vld_p2;
            if (CE && r_vld_p2) begin
                r_p_p3      <= sat_clamp(w_sum_p2, w_ovf_p2);
                r_ovf_p3    <= w_ovf_p2;
                r_sticky_p3 <= r_sticky_p3 | w_ovf_p2;
            end
        end
    end

    assign BCOUT      = r_b_p1;
    assign M          = r_m_p2;
    assign P          = r_p_p3;
    assign PCOUT      = r_p_p3;
    assign out_valid  = r_vld_p3;
    assign OVF        = r_ovf_p3;
    assign OVF_STICKY = r_sticky_p3;

endmodule

// File: tb/tb_dsp_mac_pipe.sv
// Scoreboard bench for dsp_mac_pipe: a saturating DIRECT slice and a wrapping
// CASCADE slice run side by side on the same directed vectors.
module tb_dsp_mac_pipe;

    localparam int AW = 18;
    localparam int BW = 18;
    localparam int PW = 48;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  RST_N, CE, CLR, in_valid;
    logic signed [AW-1:0]  A;
    logic signed [BW-1:0]  B, BCIN, D;
    logic signed [PW-1:0]  C, PCIN;
    logic [5:0]            OPMODE;

    logic signed [BW-1:0]  bcout_s, bcout_w;
    logic signed [AW+BW:0] m_s, m_w;
    logic signed [PW-1:0]  p_s, p_w, pcout_s, pcout_w;
    logic                  ov_s, ov_w, ovf_s, ovf_w, st_s, st_w;

    dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .B_INPUT("DIRECT"), .SAT_EN(1'b1)) dut_s (
        .clk(clk), .RST_N(RST_N), .CE(CE), .CLR(CLR), .in_valid(in_valid),
        .A(A), .B(B), .BCIN(BCIN), .D(D), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
        .BCOUT(bcout_s), .M(m_s), .P(p_s), .PCOUT(pcout_s),
        .out_valid(ov_s), .OVF(ovf_s), .OVF_STICKY(st_s)
    );

    // B and BCIN are swapped here, so this slice only sees the real operand via cascade.
    dsp_mac_pipe #(.AW(AW), .BW(BW), .PW(PW), .B_INPUT("CASCADE"), .SAT_EN(1'b0)) dut_w (
        .clk(clk), .RST_N(RST_N), .CE(CE), .CLR(CLR), .in_valid(in_valid),
        .A(A), .B(BCIN), .BCIN(B), .D(D), .C(C), .PCIN(PCIN), .OPMODE(OPMODE),
        .BCOUT(bcout_w), .M(m_w), .P(p_w), .PCOUT(pcout_w),
        .out_valid(ov_w), .OVF(ovf_w), .OVF_STICKY(st_w)
    );

    typedef struct {
        logic [PW-1:0] p_sat;
        logic [PW-1:0] p_wrap;
        logic          ovf;
        logic          sticky;
    } exp_t;

    exp_t q_s[$];
    exp_t q_w[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic mon_en = 1'b0;
    logic ce_q = 1'b1;

    always @(posedge clk) ce_q <= CE;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (!ce_q) check("stall_out_valid", PW'(ov_s), '0);
            if (ov_s) begin
                if (q_s.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_valid_sat: actual P %h required no result", p_s);
                end else begin
                    e = q_s.pop_front();
                    check("P_sat", p_s, e.p_sat);
                    check("PCOUT_sat", pcout_s, e.p_sat);
                    check("OVF_sat", PW'(ovf_s), PW'(e.ovf));
                    check("STICKY_sat", PW'(st_s), PW'(e.sticky));
                end
            end
            if (ov_w) begin
                if (q_w.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_valid_wrap: actual P %h required no result", p_w);
                end else begin
                    e = q_w.pop_front();
                    check("P_wrap", p_w, e.p_wrap);
                    check("PCOUT_wrap", pcout_w, e.p_wrap);
                    check("OVF_wrap", PW'(ovf_w), PW'(e.ovf));
                    check("STICKY_wrap", PW'(st_w), PW'(e.sticky));
                end
            end
        end
    end

    task automatic op(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                      input logic signed [BW-1:0] d, input logic signed [PW-1:0] c,
                      input logic signed [PW-1:0] pc, input logic [5:0] om, input logic push,
                      input logic [PW-1:0] ep_s, input logic [PW-1:0] ep_w,
                      input logic eo, input logic es);
        exp_t e;
        A = a; B = b; BCIN = ~b; D = d; C = c; PCIN = pc; OPMODE = om;
        in_valid = 1'b1; CE = 1'b1; CLR = 1'b0;
        if (push) begin
            e = '{p_sat: ep_s, p_wrap: ep_w, ovf: eo, sticky: es};
            q_s.push_back(e);
            q_w.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0; CE = 1'b1; CLR = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic stall(input int n);
        CE = 1'b0; in_valid = 1'b1; A = 100; B = 100; BCIN = -100;
        repeat (n) @(negedge clk);
        CE = 1'b1;
    endtask

    task automatic clear();
        CLR = 1'b1; in_valid = 1'b0; CE = 1'b1;
        @(negedge clk);
        CLR = 1'b0;
    endtask

    function automatic logic any_out();
        return |{bcout_s, m_s, p_s, pcout_s, ov_s, ovf_s, st_s,
                 bcout_w, m_w, p_w, pcout_w, ov_w, ovf_w, st_w};
    endfunction

    initial begin
        RST_N = 1'b0; CE = 1'b1; CLR = 1'b0; in_valid = 1'b1;
        A = '0; B = '0; BCIN = '0; D = '0; C = '0; PCIN = '0; OPMODE = '0;

        // Reset held with live random traffic
        for (int i = 0; i < 10; i++) begin
            A = AW'($urandom); B = BW'($urandom); BCIN = BW'($urandom); D = BW'($urandom);
            C = {$urandom, $urandom}; PCIN = {$urandom, $urandom}; OPMODE = 6'($urandom);
            @(negedge clk);
            check("reset_outputs", PW'(any_out()), '0);
        end

        RST_N = 1'b1;
        mon_en = 1'b1;
        op(2, 3, 0, 0, 0, 6'b000000, 1'b1, 6, 6, 1'b0, 1'b0);
        check("latency_edge1", PW'(ov_s), '0);
        idle(1);
        check("latency_edge2", PW'(ov_s), '0);
        idle(1);
        check("latency_edge3", PW'({ov_s, ov_w}), 2'b11);

        // Pre-add, pre-subtract, PCIN and post-subtract with carry-in
        op(20, 10, 25, 350, 0, 6'b001001, 1'b1, 1050, 1050, 1'b0, 1'b0);
        check("BCOUT_direct", bcout_s, 10);
        check("BCOUT_cascade", bcout_w, 10);
        op(6, 10, 5, 0, 0, 6'b000011, 1'b1, 48'hFFFF_FFFF_FFE2, 48'hFFFF_FFFF_FFE2, 1'b0, 1'b0);
        check("M_preadd", m_s, 700);
        op(-2, 7, 0, 0, 1000, 6'b001100, 1'b1, 986, 986, 1'b0, 1'b0);
        check("M_presub", m_s, -30);
        op(5, 6, 0, 100, 0, 6'b111000, 1'b1, 69, 69, 1'b0, 1'b0);
        idle(3);
        clear();
        check("P_after_clr", p_s, '0);

        // Back-to-back accumulate, then the same stream with a two-cycle stall
        for (int k = 1; k <= 4; k++)
            op(3, 4, 0, 0, 0, 6'b000100, 1'b1, PW'(12 * k), PW'(12 * k), 1'b0, 1'b0);
        idle(3);
        clear();
        op(3, 4, 0, 0, 0, 6'b000100, 1'b1, 12, 12, 1'b0, 1'b0);
        op(3, 4, 0, 0, 0, 6'b000100, 1'b1, 24, 24, 1'b0, 1'b0);
        stall(2);
        op(3, 4, 0, 0, 0, 6'b000100, 1'b1, 36, 36, 1'b0, 1'b0);
        op(3, 4, 0, 0, 0, 6'b000100, 1'b1, 48, 48, 1'b0, 1'b0);
        idle(3);

        // Positive and negative overflow, then a clean op keeps the sticky flag
        op(1, 1, 0, 48'h7FFF_FFFF_FFFF, 0, 6'b001000, 1'b1,
           48'h7FFF_FFFF_FFFF, 48'h8000_0000_0000, 1'b1, 1'b1);
        op(1, 1, 0, 48'h8000_0000_0000, 0, 6'b011000, 1'b1,
           48'h8000_0000_0000, 48'h7FFF_FFFF_FFFF, 1'b1, 1'b1);
        op(2, 2, 0, 0, 0, 6'b000000, 1'b1, 4, 4, 1'b0, 1'b1);
        idle(3);

        // Flush two in-flight operations
        op(9, 9, 0, 5, 0, 6'b001000, 1'b0, '0, '0, 1'b0, 1'b0);
        op(7, 7, 0, 5, 0, 6'b001000, 1'b0, '0, '0, 1'b0, 1'b0);
        clear();
        check("flush_out_valid", PW'(ov_s), '0);
        check("flush_P", p_s, '0);
        check("flush_sticky", PW'({st_s, st_w}), '0);
        check("flush_M_BCOUT", PW'(|{m_s, bcout_s}), '0);
        idle(4);

        // Asynchronous reset between edges
        op(-2, 7, 0, 0, 1000, 6'b001100, 1'b1, 986, 986, 1'b0, 1'b0);
        idle(3);
        check("pre_async_P", p_s, 986);
        #2 RST_N = 1'b0;
        #1 check("async_reset_outputs", PW'(any_out()), '0);
        @(negedge clk);
        RST_N = 1'b1;
        idle(2);

        for (int i = 0; i < 20 && (q_s.size() != 0 || q_w.size() != 0); i++) @(negedge clk);
        check("queue_drained", PW'(q_s.size() + q_w.size()), '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
